// File: rtl/des_ks_fp_unit.sv
// DES helper datapath: one key-schedule step (rotate C||D, PC-2) and the
// output merge with the final permutation, behind one valid-qualified register.
module des_ks_fp_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [55:0] ks_x,
    input  logic [3:0]  ks_i,
    input  logic [31:0] x0,
    input  logic [31:0] x1,
    output logic        out_valid,
    output logic [55:0] ks_r,
    output logic [47:0] ks_k,
    output logic [63:0] c
);

    // Table entries are DES bit numbers: entry n selects input bit [W-n].
    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    localparam int FP_TAB [64] = '{
        40,  8, 48, 16, 56, 24, 64, 32,
        39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30,
        37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28,
        35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26,
        33,  1, 41,  9, 49, 17, 57, 25
    };

    logic        out_valid_q, out_valid_d;
    logic [55:0] ks_r_q, ks_r_d;
    logic [47:0] ks_k_q, ks_k_d;
    logic [63:0] c_q, c_d;

    logic        rot_one;
    logic [27:0] c_half, d_half, c_rot, d_rot;
    logic [55:0] ks_r_new;
    logic [47:0] ks_k_new;
    logic [63:0] merged, c_new;

    always_comb begin
        rot_one  = (ks_i == 4'd0) || (ks_i == 4'd1) || (ks_i == 4'd8) || (ks_i == 4'd15);
        c_half   = ks_x[55:28];
        d_half   = ks_x[27:0];
        c_rot    = rot_one ? {c_half[26:0], c_half[27]} : {c_half[25:0], c_half[27:26]};
        d_rot    = rot_one ? {d_half[26:0], d_half[27]} : {d_half[25:0], d_half[27:26]};
        ks_r_new = {c_rot, d_rot};

        ks_k_new = '0;
        for (int j = 0; j < 48; j++) begin
            ks_k_new[47-j] = ks_r_new[56-PC2_TAB[j]];
        end

        merged = {x0, x1};
        c_new  = '0;
        for (int j = 0; j < 64; j++) begin
            c_new[63-j] = merged[64-FP_TAB[j]];
        end
    end

    // Data registers only load on an accepted input; valid is a one-cycle pulse.
    always_comb begin
        out_valid_d = in_valid;
        ks_r_d      = ks_r_q;
        ks_k_d      = ks_k_q;
        c_d         = c_q;
        if (in_valid) begin
            ks_r_d = ks_r_new;
            ks_k_d = ks_k_new;
            c_d    = c_new;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            ks_r_q      <= '0;
            ks_k_q      <= '0;
            c_q         <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            ks_r_q      <= ks_r_d;
            ks_k_q      <= ks_k_d;
            c_q         <= c_d;
        end
    end

    assign out_valid = out_valid_q;
    assign ks_r      = ks_r_q;
    assign ks_k      = ks_k_q;
    assign c         = c_q;

endmodule

// File: tb/tb_des_ks_fp_unit.sv
// Self-checking bench for des_ks_fp_unit: known-answer vector table, corner
// sequences and randomized traffic against a behavioural model.
module tb_des_ks_fp_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [55:0] ks_x;
    logic [3:0]  ks_i;
    logic [31:0] x0;
    logic [31:0] x1;
    logic        out_valid;
    logic [55:0] ks_r;
    logic [47:0] ks_k;
    logic [63:0] c;

    int total = 0;
    int bad   = 0;

    logic        exp_valid;
    logic [55:0] exp_r;
    logic [47:0] exp_k;
    logic [63:0] exp_c;

    des_ks_fp_unit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .ks_x      (ks_x),
        .ks_i      (ks_i),
        .x0        (x0),
        .x1        (x1),
        .out_valid (out_valid),
        .ks_r      (ks_r),
        .ks_k      (ks_k),
        .c         (c)
    );

    always #5 clk = ~clk;

    // Left-shift schedule of the 16 DES rounds.
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    function automatic logic [27:0] rotl28(input logic [27:0] v, input int n);
        return (v << n) | (v >> (28 - n));
    endfunction

    function automatic logic [55:0] model_ks_r(input logic [55:0] kx, input logic [3:0] ki);
        int n;
        n = SHIFTS[ki];
        return {rotl28(kx[55:28], n), rotl28(kx[27:0], n)};
    endfunction

    function automatic logic [47:0] model_pc2(input logic [55:0] r);
        logic [47:0] k;
        k = '0;
        for (int j = 0; j < 48; j++) k[47-j] = r[56-PC2[j]];
        return k;
    endfunction

    // FP modelled as the inverse of IP, with IP generated from its row pattern.
    function automatic logic [63:0] model_fp(input logic [63:0] m);
        logic [63:0] o;
        int base, ipv;
        o = '0;
        for (int r = 0; r < 8; r++) begin
            base = (r < 4) ? 2 * (r + 1) : 2 * (r - 4) + 1;
            for (int k = 0; k < 8; k++) begin
                ipv = base + 8 * (7 - k);
                o[64-ipv] = m[63-(r*8+k)];
            end
        end
        return o;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic apply_cycle(input string name, input logic r, input logic v,
                               input logic [55:0] kx, input logic [3:0] ki,
                               input logic [31:0] a, input logic [31:0] b);
        rst      = r;
        in_valid = v;
        ks_x     = kx;
        ks_i     = ki;
        x0       = a;
        x1       = b;
        @(posedge clk);
        #1;
        if (r) begin
            exp_valid = 1'b0;
            exp_r = '0;
            exp_k = '0;
            exp_c = '0;
        end else if (v) begin
            exp_valid = 1'b1;
            exp_r = model_ks_r(kx, ki);
            exp_k = model_pc2(exp_r);
            exp_c = model_fp({a, b});
        end else begin
            exp_valid = 1'b0;
        end
        check({name, ".out_valid"}, 64'(out_valid), 64'(exp_valid));
        check({name, ".ks_r"}, 64'(ks_r), 64'(exp_r));
        check({name, ".ks_k"}, 64'(ks_k), 64'(exp_k));
        check({name, ".c"}, c, exp_c);
    endtask

    typedef struct {
        logic [55:0] kx;
        logic [3:0]  ki;
        logic [31:0] a;
        logic [31:0] b;
        logic [55:0] r;
        logic [47:0] k;
        logic [63:0] cc;
    } vec_t;

    vec_t vecs [3];

    initial begin
        logic [55:0] kx;
        logic [55:0] held_r;

        vecs[0] = '{56'hF0CCAAF556678F, 4'd0, 32'h0A4CD995, 32'h43423234,
                    56'hE19955FAACCF1E, 48'h1B02EFFC7072, 64'h85E813540F0AB405};
        vecs[1] = '{56'hE19955FAACCF1E, 4'd1, 32'hCC00CCFF, 32'hF0AAF0AA,
                    56'hC332ABF5599E3D, 48'h79AED9DBC9E5, 64'h0123456789ABCDEF};
        vecs[2] = '{56'hC332ABF5599E3D, 4'd2, 32'h00000000, 32'h00000000,
                    56'h0CCAAFF56678F5, 48'h55FC8A42CF99, 64'h0};

        exp_valid = 1'b0;
        exp_r = '0;
        exp_k = '0;
        exp_c = '0;

        // Reset with a valid, nonzero input present.
        apply_cycle("reset", 1'b1, 1'b1, 56'hFFFFFFFFFFFFFF, 4'd3, 32'hDEADBEEF, 32'h12345678);
        apply_cycle("reset2", 1'b1, 1'b1, 56'hA5A5A5A5A5A5A5, 4'd9, 32'hFFFFFFFF, 32'hFFFFFFFF);
        apply_cycle("idle", 1'b0, 1'b0, 56'h0, 4'd0, 32'h0, 32'h0);

        // Known-answer vectors applied back to back.
        for (int i = 0; i < 3; i++) begin
            apply_cycle($sformatf("vec%0d", i), 1'b0, 1'b1, vecs[i].kx, vecs[i].ki, vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d.kat_r", i), 64'(ks_r), 64'(vecs[i].r));
            check($sformatf("vec%0d.kat_k", i), 64'(ks_k), 64'(vecs[i].k));
            check($sformatf("vec%0d.kat_c", i), c, vecs[i].cc);
        end

        // Sixteen chained steps must bring C||D back to the starting state.
        kx = 56'hF0CCAAF556678F;
        for (int i = 0; i < 16; i++) begin
            apply_cycle($sformatf("wrap%0d", i), 1'b0, 1'b1, kx, 4'(i), $urandom, $urandom);
            kx = exp_r;
        end
        check("wrap.final_ks_r", 64'(ks_r), 64'h00F0CCAAF556678F);

        // Hold: three idle cycles with changing inputs must not disturb outputs.
        apply_cycle("hold.load", 1'b0, 1'b1, 56'h13579BDF02468A, 4'd5, 32'h89ABCDEF, 32'h01234567);
        held_r = exp_r;
        for (int i = 0; i < 3; i++) begin
            apply_cycle($sformatf("hold%0d", i), 1'b0, 1'b0,
                        {$urandom, $urandom}, 4'($urandom), $urandom, $urandom);
        end
        check("hold.ks_r_kept", 64'(ks_r), 64'(held_r));

        // Reset mid-stream beats a simultaneous valid input.
        apply_cycle("prio.a", 1'b0, 1'b1, 56'hFEDCBA98765432, 4'd7, 32'h11111111, 32'h22222222);
        apply_cycle("prio.rst", 1'b1, 1'b1, 56'h0123456789ABCD, 4'd8, 32'h33333333, 32'h44444444);
        apply_cycle("prio.idle", 1'b0, 1'b0, 56'h0123456789ABCD, 4'd8, 32'h33333333, 32'h44444444);
        apply_cycle("prio.first", 1'b0, 1'b1, 56'h0123456789ABCD, 4'd15, 32'h55555555, 32'h66666666);

        // Randomized traffic against the model.
        for (int i = 0; i < 300; i++) begin
            apply_cycle("rand", ($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0),
                        {$urandom, $urandom}, 4'($urandom), $urandom, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
